tage_table_sweep: RTL and testbench



---
 rtl/tage_table_sweep_if.sv | 36 +++
 rtl/tage_table_sweep.sv | 166 ++++++++++++++++
 tb/tb_tage_table_sweep.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tage_table_sweep_if.sv
// Read/write bundle between the TAGE index hashing logic (master) and one
// tagged component table (slave).
interface tage_table_sweep_if #(
  parameter int AW       = 6,
  parameter int TAG_SIZE = 8
);
  logic [AW-1:0]       IN_readAddr;
  logic [TAG_SIZE-1:0] IN_readTag;
  logic                OUT_readValid;
  logic                OUT_readTaken;
  logic                OUT_readConf;
  logic                OUT_ready;
  logic                IN_writeValid;
  logic [AW-1:0]       IN_writeAddr;
  logic [TAG_SIZE-1:0] IN_writeTag;
  logic                IN_writeTaken;
  logic                IN_writeNew;
  logic                IN_writeUseful;
  logic                IN_writeUpdate;
  logic                OUT_writeAlloc;
  logic                IN_anyAlloc;

  modport master (
    output IN_readAddr, IN_readTag,
    output IN_writeValid, IN_writeAddr, IN_writeTag, IN_writeTaken,
    output IN_writeNew, IN_writeUseful, IN_writeUpdate, IN_anyAlloc,
    input  OUT_readValid, OUT_readTaken, OUT_readConf, OUT_ready, OUT_writeAlloc
  );

  modport slave (
    input  IN_readAddr, IN_readTag,
    input  IN_writeValid, IN_writeAddr, IN_writeTag, IN_writeTaken,
    input  IN_writeNew, IN_writeUseful, IN_writeUpdate, IN_anyAlloc,
    output OUT_readValid, OUT_readTaken, OUT_readConf, OUT_ready, OUT_writeAlloc
  );
endinterface

// File: rtl/tage_table_sweep.sv
// Tagged TAGE component table: direct-mapped {tag, useful, cnt} array with a
// power-up clear sweep and a one-entry-per-cycle useful-bit aging sweep.
module tage_table_sweep #(
  parameter int SIZE     = 64,
  parameter int TAG_SIZE = 8,
  parameter int USF_SIZE = 2,
  parameter int CNT_SIZE = 2,
  parameter int INTERVAL = 10
) (
  input  logic              clk,
  input  logic              rst,
  tage_table_sweep_if.slave bus
);
  localparam int AW = $clog2(SIZE);

  generate
    if (SIZE < 4 || (SIZE & (SIZE - 1)) != 0) begin : gSizeCheck
      $error("tage_table_sweep: SIZE must be a power of two and at least 4");
    end
    if (CNT_SIZE < 2) begin : gCntCheck
      $error("tage_table_sweep: CNT_SIZE must be at least 2");
    end
    if ((64'(1) << INTERVAL) <= 64'(2 * SIZE)) begin : gIntervalCheck
      $error("tage_table_sweep: 2**INTERVAL must exceed 2*SIZE");
    end
  endgenerate

  typedef struct packed {
    logic [TAG_SIZE-1:0] tag;
    logic [USF_SIZE-1:0] useful;
    logic [CNT_SIZE-1:0] cnt;
  } entryT;

  typedef enum logic [1:0] {INIT, IDLE, AGE} stateT;

  entryT               mem [SIZE];
  stateT               state;
  logic [AW-1:0]       sweepIdx;
  logic [INTERVAL-1:0] ageCnt;

  logic ready;
  logic writeEn;
  logic collision;
  logic lastIdx;

  entryT wrOld;
  entryT wrNew;
  entryT sweepOld;
  entryT sweepNew;
  entryT rdEntry;
  logic  isUpdate;
  logic  isAlloc;
  logic  allocWins;

  logic readValid;
  logic readTaken;
  logic readConf;

  assign ready     = (state != INIT);
  assign writeEn   = ready && bus.IN_writeValid;
  assign collision = (state == AGE) && writeEn && (bus.IN_writeAddr == sweepIdx);
  assign lastIdx   = (sweepIdx == AW'(SIZE - 1));
  assign rdEntry   = mem[bus.IN_readAddr];
  assign sweepOld  = mem[sweepIdx];

  // Write-port result for the addressed entry; the entry is rewritten
  // unchanged when the request is neither an update nor an allocation.
  always_comb begin
    wrOld     = mem[bus.IN_writeAddr];
    wrNew     = wrOld;
    isUpdate  = bus.IN_writeValid && bus.IN_writeUpdate;
    isAlloc   = bus.IN_writeValid && !bus.IN_writeUpdate && bus.IN_writeNew;
    allocWins = isAlloc && (wrOld.useful == '0);
    if (isUpdate) begin
      if (bus.IN_writeTaken) begin
        if (wrOld.cnt != '1) wrNew.cnt = wrOld.cnt + 1'b1;
      end else begin
        if (wrOld.cnt != '0) wrNew.cnt = wrOld.cnt - 1'b1;
      end
      if (bus.IN_writeUseful) begin
        if (wrOld.useful != '1) wrNew.useful = wrOld.useful + 1'b1;
      end else begin
        if (wrOld.useful != '0) wrNew.useful = wrOld.useful - 1'b1;
      end
    end else if (allocWins) begin
      wrNew.tag    = bus.IN_writeTag;
      wrNew.useful = '0;
      wrNew.cnt    = {bus.IN_writeTaken, {(CNT_SIZE - 1){1'b0}}};
    end else if (isAlloc && !bus.IN_anyAlloc) begin
      wrNew.useful = wrOld.useful - 1'b1;
    end
  end

  always_comb begin
    sweepNew = sweepOld;
    if (sweepOld.useful != '0) sweepNew.useful = sweepOld.useful - 1'b1;
  end

  // The array itself carries no reset; the INIT sweep clears it instead.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[sweepIdx] <= '0;
    end else begin
      if (state == AGE && !collision) mem[sweepIdx] <= sweepNew;
      if (writeEn) mem[bus.IN_writeAddr] <= wrNew;
    end
  end

  // The aging counter resets to 0, so the first aging sweep follows init
  // immediately; leaving IDLE wraps it to all-ones for the next period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      sweepIdx <= '0;
      ageCnt   <= '0;
    end else begin
      case (state)
        INIT: begin
          sweepIdx <= sweepIdx + 1'b1;
          if (lastIdx) state <= IDLE;
        end
        IDLE: begin
          ageCnt <= ageCnt - 1'b1;
          if (ageCnt == '0) begin
            state    <= AGE;
            sweepIdx <= '0;
          end
        end
        AGE: begin
          if (!collision) begin
            sweepIdx <= sweepIdx + 1'b1;
            if (lastIdx) state <= IDLE;
          end
        end
        default: begin
          state    <= INIT;
          sweepIdx <= '0;
        end
      endcase
    end
  end

  // Read sees the array as it was before this cycle's write and sweep step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      readValid <= 1'b0;
      readTaken <= 1'b0;
      readConf  <= 1'b0;
    end else if (state == INIT) begin
      readValid <= 1'b0;
      readTaken <= 1'b0;
      readConf  <= 1'b0;
    end else begin
      readValid <= (rdEntry.tag == bus.IN_readTag);
      readTaken <= rdEntry.cnt[CNT_SIZE-1];
      readConf  <= (rdEntry.cnt == '0) || (rdEntry.cnt == '1);
    end
  end

  assign bus.OUT_readValid  = readValid;
  assign bus.OUT_readTaken  = readTaken;
  assign bus.OUT_readConf   = readConf;
  assign bus.OUT_ready      = ready;
  assign bus.OUT_writeAlloc = ready && allocWins;

endmodule

// File: tb/tb_tage_table_sweep.sv
// Directed bench for tage_table_sweep: init sweep, update/allocate vectors,
// aging sweep with a collision stall, and a mid-sweep reset.
module tb_tage_table_sweep;
  localparam int SIZE = 64;
  localparam int AW   = 6;
  localparam int TS   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tage_table_sweep_if #(.AW(AW), .TAG_SIZE(TS)) bus ();

  tage_table_sweep #(
    .SIZE(SIZE), .TAG_SIZE(TS), .USF_SIZE(2), .CNT_SIZE(2), .INTERVAL(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  int nChecks = 0;
  int nPass   = 0;
  bit watch   = 1'b0;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] wAddr;
    logic [TS-1:0] wTag;
    logic          taken;
    logic          isNew;
    logic          useful;
    logic          upd;
    logic          any;
    logic          expAlloc;
    logic          rd;
    logic [AW-1:0] rAddr;
    logic [TS-1:0] rTag;
    logic          expValid;
    logic          expTaken;
    logic          expConf;
  } vecT;

  vecT vecs[$];

  task automatic check(input string name, input logic act, input logic exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, exp, cyc);
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic checkRd(input string name, input logic v, input logic t, input logic c);
    check({name, ".valid"}, bus.OUT_readValid, v);
    check({name, ".taken"}, bus.OUT_readTaken, t);
    check({name, ".conf"},  bus.OUT_readConf,  c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (watch) checkRd("sweepRead", 1'b1, 1'b1, 1'b0);
  endtask

  task automatic waitCyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 5000) begin
      tick();
      guard++;
    end
    checkInt("waitCyc", cyc, n);
  endtask

  task automatic clearWrite();
    bus.IN_writeValid  = 1'b0;
    bus.IN_writeUpdate = 1'b0;
    bus.IN_writeNew    = 1'b0;
    bus.IN_writeUseful = 1'b0;
    bus.IN_writeTaken  = 1'b0;
    bus.IN_anyAlloc    = 1'b0;
  endtask

  // Combinational look at useful==0 of one entry; cleared before the edge so nothing commits.
  task automatic probeAlloc(input string name, input int a, input logic exp);
    bus.IN_writeValid  = 1'b1;
    bus.IN_writeUpdate = 1'b0;
    bus.IN_writeNew    = 1'b1;
    bus.IN_anyAlloc    = 1'b1;
    bus.IN_writeAddr   = AW'(a);
    #1;
    check(name, bus.OUT_writeAlloc, exp);
    $display("probe %s addr=%0d alloc=%b", name, a, bus.OUT_writeAlloc);
    clearWrite();
  endtask

  task automatic commitWrite(input int a, input int tg, input logic tk, input logic nw,
                             input logic us, input logic up, input logic an);
    bus.IN_writeValid  = 1'b1;
    bus.IN_writeAddr   = AW'(a);
    bus.IN_writeTag    = TS'(tg);
    bus.IN_writeTaken  = tk;
    bus.IN_writeNew    = nw;
    bus.IN_writeUseful = us;
    bus.IN_writeUpdate = up;
    bus.IN_anyAlloc    = an;
  endtask

  function automatic vecT mkW(input int a, input int tg, input logic tk, input logic nw,
                              input logic us, input logic up, input logic an, input logic ea);
    vecT v = '0;
    v.wr = 1'b1; v.wAddr = AW'(a); v.wTag = TS'(tg); v.taken = tk; v.isNew = nw;
    v.useful = us; v.upd = up; v.any = an; v.expAlloc = ea;
    return v;
  endfunction

  function automatic vecT addR(input vecT vin, input int a, input int tg,
                               input logic ev, input logic et, input logic ec);
    vecT v = vin;
    v.rd = 1'b1; v.rAddr = AW'(a); v.rTag = TS'(tg);
    v.expValid = ev; v.expTaken = et; v.expConf = ec;
    return v;
  endfunction

  task automatic runVecs();
    vecT v;
    foreach (vecs[i]) begin
      v = vecs[i];
      bus.IN_writeValid  = v.wr;
      bus.IN_writeAddr   = v.wAddr;
      bus.IN_writeTag    = v.wTag;
      bus.IN_writeTaken  = v.taken;
      bus.IN_writeNew    = v.isNew;
      bus.IN_writeUseful = v.useful;
      bus.IN_writeUpdate = v.upd;
      bus.IN_anyAlloc    = v.any;
      if (v.rd) begin
        bus.IN_readAddr = v.rAddr;
        bus.IN_readTag  = v.rTag;
      end
      #1;
      if (v.wr) check($sformatf("vec%0d.alloc", i), bus.OUT_writeAlloc, v.expAlloc);
      tick();
      clearWrite();
      if (v.rd) checkRd($sformatf("vec%0d", i), v.expValid, v.expTaken, v.expConf);
      $display("vec %0d wr=%b addr=%0d rd=%b raddr=%0d valid=%b taken=%b conf=%b",
               i, v.wr, v.wAddr, v.rd, v.rAddr,
               bus.OUT_readValid, bus.OUT_readTaken, bus.OUT_readConf);
    end
    vecs.delete();
  endtask

  initial begin
    int rise;
    vecT none;
    none = '0;
    clearWrite();
    bus.IN_writeAddr = '0;
    bus.IN_writeTag  = '0;
    bus.IN_readAddr  = AW'(2);
    bus.IN_readTag   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rstReady", bus.OUT_ready, 1'b0);
    checkRd("rstRead", 1'b0, 1'b0, 1'b0);

    // Init sweep, with a write attempt that must be ignored.
    rst  = 1'b1;
    rise = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (cyc == 11) clearWrite();
      if (cyc == 10) begin
        commitWrite(2, 'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("initAlloc", bus.OUT_writeAlloc, 1'b0);
        check("initReadValid", bus.OUT_readValid, 1'b0);
      end
      if (bus.OUT_ready) begin
        rise = cyc;
        break;
      end
    end
    checkInt("initLength", rise, 64);

    vecs.push_back(addR(none, 0,  'h00, 1'b1, 1'b0, 1'b1));
    vecs.push_back(addR(none, 63, 'h00, 1'b1, 1'b0, 1'b1));
    vecs.push_back(addR(none, 2,  'h00, 1'b1, 1'b0, 1'b1));
    vecs.push_back(addR(none, 31, 'h5A, 1'b0, 1'b0, 1'b1));
    vecs.push_back(addR(none, 7,  'h00, 1'b1, 1'b0, 1'b1));
    runVecs();

    waitCyc(140);
    // Each read sees the entry before the same vector's write.
    vecs.push_back(addR(mkW(5, 'hA3, 1, 1, 0, 0, 0, 1), 5, 'hA3, 0, 0, 1));
    vecs.push_back(addR(none, 5, 'hA3, 1, 1, 0));
    vecs.push_back(addR(none, 5, 'hA4, 0, 1, 0));
    vecs.push_back(addR(mkW(5, 0, 1, 0, 0, 1, 0, 0), 5, 'hA3, 1, 1, 0));
    vecs.push_back(addR(mkW(5, 0, 1, 0, 0, 1, 0, 0), 5, 'hA3, 1, 1, 1));
    vecs.push_back(addR(mkW(5, 0, 1, 0, 0, 1, 0, 0), 5, 'hA3, 1, 1, 1));
    vecs.push_back(addR(mkW(5, 0, 1, 0, 0, 1, 0, 0), 5, 'hA3, 1, 1, 1));
    vecs.push_back(addR(mkW(5, 0, 1, 0, 0, 1, 0, 0), 5, 'hA3, 1, 1, 1));
    vecs.push_back(addR(mkW(5, 0, 0, 0, 0, 1, 0, 0), 5, 'hA3, 1, 1, 1));
    vecs.push_back(addR(mkW(5, 0, 0, 0, 0, 1, 0, 0), 5, 'hA3, 1, 1, 0));
    vecs.push_back(addR(mkW(5, 0, 0, 0, 0, 1, 0, 0), 5, 'hA3, 1, 0, 0));
    vecs.push_back(addR(mkW(5, 0, 0, 0, 0, 1, 0, 0), 5, 'hA3, 1, 0, 1));
    vecs.push_back(addR(none, 5, 'hA3, 1, 0, 1));
    vecs.push_back(addR(mkW(5, 0, 1, 0, 1, 1, 0, 0), 5, 'hA3, 1, 0, 1));
    vecs.push_back(addR(mkW(5, 0, 1, 0, 1, 1, 0, 0), 5, 'hA3, 1, 0, 0));
    vecs.push_back(addR(mkW(5, 0, 1, 0, 1, 1, 0, 0), 5, 'hA3, 1, 1, 0));
    vecs.push_back(addR(mkW(5, 'h11, 0, 1, 0, 0, 1, 0), 5, 'hA3, 1, 1, 1));
    vecs.push_back(mkW(5, 'h11, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mkW(5, 'h11, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mkW(5, 'h11, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mkW(5, 'h11, 0, 1, 0, 0, 0, 0));
    vecs.push_back(addR(mkW(5, 'h11, 0, 1, 0, 0, 1, 1), 5, 'hA3, 1, 1, 1));
    vecs.push_back(addR(none, 5, 'h11, 1, 0, 1));
    vecs.push_back(addR(none, 5, 'hA3, 0, 0, 1));
    vecs.push_back(mkW(5, 0, 1, 0, 1, 1, 0, 0));
    vecs.push_back(addR(mkW(5, 0, 1, 0, 1, 1, 0, 0), 5, 'h11, 1, 0, 0));
    vecs.push_back(addR(mkW(10, 'h22, 0, 1, 0, 0, 0, 1), 5, 'h11, 1, 1, 0));
    vecs.push_back(addR(mkW(10, 0, 0, 0, 1, 1, 0, 0), 10, 'h22, 1, 0, 1));
    vecs.push_back(addR(mkW(20, 'h33, 1, 1, 0, 0, 0, 1), 10, 'h22, 1, 0, 1));
    vecs.push_back(addR(mkW(20, 0, 1, 0, 1, 1, 0, 0), 20, 'h33, 1, 1, 0));
    vecs.push_back(addR(none, 20, 'h33, 1, 1, 1));
    vecs.push_back(addR(mkW(20, 'h44, 0, 1, 0, 0, 1, 0), 2, 'h00, 1, 0, 1));
    vecs.push_back(addR(none, 20, 'h44, 0, 1, 1));
    runVecs();

    // Second aging sweep: AGE entered at edge 1153, entry i aged at edge 1154+i.
    bus.IN_readAddr = AW'(5);
    bus.IN_readTag  = TS'('h11);
    waitCyc(1140);
    watch = 1'b1;
    waitCyc(1158);
    probeAlloc("preAge5", 5, 1'b0);
    waitCyc(1163);
    commitWrite(10, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    clearWrite();
    probeAlloc("collide10", 10, 1'b0);
    waitCyc(1174);
    probeAlloc("stall20", 20, 1'b0);
    tick();
    probeAlloc("aged20", 20, 1'b1);
    waitCyc(1176);
    commitWrite(5, 'h99, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("decay5.alloc", bus.OUT_writeAlloc, 1'b0);
    tick();
    clearWrite();
    probeAlloc("aged5", 5, 1'b1);
    commitWrite(10, 'h99, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("decay10.alloc", bus.OUT_writeAlloc, 1'b0);
    tick();
    clearWrite();
    probeAlloc("aged10", 10, 1'b1);

    // Mid-sweep reset and full re-clear.
    waitCyc(1180);
    watch = 1'b0;
    rst   = 1'b0;
    #1;
    check("midRstReady", bus.OUT_ready, 1'b0);
    check("midRstValid", bus.OUT_readValid, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst  = 1'b1;
    rise = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (bus.OUT_ready) begin
        rise = cyc;
        break;
      end
    end
    checkInt("reinitLength", rise, 64);
    vecs.push_back(addR(none, 5,  'h00, 1'b1, 1'b0, 1'b1));
    vecs.push_back(addR(none, 20, 'h00, 1'b1, 1'b0, 1'b1));
    vecs.push_back(addR(none, 10, 'h22, 1'b0, 1'b0, 1'b1));
    runVecs();
    probeAlloc("reinit5", 5, 1'b1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
